sif_wa_responder: RTL and testbench

SIF_WA_RESPONDER -- requirements
Module: sif_wa_responder

---
 rtl/sif_wa_responder.sv | 130 +++++++++++++
 tb/tb_sif_wa_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sif_wa_responder.sv
// Wait-state request/acknowledge responder backed by a 16-bit word store.
// Optional macro SIF_WA_CHECKSUM_EN adds a running checksum of committed write data on chk_sum.
module sif_wa_responder #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wa_req,
    input  logic              wa_wr,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [15:0]       wa_wdata,
    output logic              wa_ack,
    output logic              wa_err,
    output logic [15:0]       wa_rdata,
`ifdef SIF_WA_CHECKSUM_EN
    output logic [15:0]       chk_sum,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      LP_WAIT  = 4'(WAIT_CYCLES);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_rdata;
    logic              r_err;
    logic [15:0]       r_mem [DEPTH];

    logic w_accept;
    logic w_enter_ack;
    logic w_addr_err;
    logic w_commit;

    assign w_accept    = (r_state == S_IDLE) && wa_req;
    assign w_enter_ack = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_addr_err  = ({1'b0, r_addr} >= LP_DEPTH);
    assign w_commit    = w_enter_ack && r_wr && !w_addr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        wa_ack   = 1'b0;
        busy     = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (wa_req) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next = S_ACK;
            end
            S_ACK: begin
                wa_ack = 1'b1;
                w_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!wa_req) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign wa_err   = wa_ack & r_err;
    assign wa_rdata = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            r_rdata <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_cnt <= LP_WAIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_ack) begin
                r_err <= w_addr_err;
                if (!r_wr) r_rdata <= w_addr_err ? 16'h0000 : r_mem[r_addr];
            end
        end
    end

    // Request fields are captured only on acceptance; later input activity is ignored.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wr    <= wa_wr;
            r_addr  <= wa_addr;
            r_wdata <= wa_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) r_mem[r_addr] <= r_wdata;
    end

`ifdef SIF_WA_CHECKSUM_EN
    logic [15:0] r_chk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk <= 16'h0000;
        end else if (w_commit) begin
            r_chk <= r_chk + r_wdata;
        end
    end

    assign chk_sum = r_chk;
`endif

endmodule

// File: tb/tb_sif_wa_responder.sv
// Directed bench for sif_wa_responder: three instances cover wait states, zero-wait and a short DEPTH.
module tb_sif_wa_responder;

    logic        clk;
    logic        rst;
    logic        req   [3];
    logic        wr    [3];
    logic [7:0]  addr  [3];
    logic [15:0] wdata [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];
    logic [15:0] rdata [3];
`ifdef SIF_WA_CHECKSUM_EN
    logic [15:0] chk   [3];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sif_wa_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .wa_req(req[0]), .wa_wr(wr[0]), .wa_addr(addr[0]),
        .wa_wdata(wdata[0]), .wa_ack(ack[0]), .wa_err(err[0]), .wa_rdata(rdata[0]),
`ifdef SIF_WA_CHECKSUM_EN
        .chk_sum(chk[0]),
`endif
        .busy(busy[0]));

    sif_wa_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .wa_req(req[1]), .wa_wr(wr[1]), .wa_addr(addr[1]),
        .wa_wdata(wdata[1]), .wa_ack(ack[1]), .wa_err(err[1]), .wa_rdata(rdata[1]),
`ifdef SIF_WA_CHECKSUM_EN
        .chk_sum(chk[1]),
`endif
        .busy(busy[1]));

    sif_wa_responder #(.ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .wa_req(req[2]), .wa_wr(wr[2]), .wa_addr(addr[2]),
        .wa_wdata(wdata[2]), .wa_ack(ack[2]), .wa_err(err[2]), .wa_rdata(rdata[2]),
`ifdef SIF_WA_CHECKSUM_EN
        .chk_sum(chk[2]),
`endif
        .busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full handshake on instance d; ack latency counted in clocks after the accepting edge.
    task automatic txn(input int d, input bit w, input logic [7:0] a, input logic [15:0] dt,
                       input int lat, input bit exp_err, input logic [15:0] exp_rd,
                       input bit scramble, input int hold, input string tag);
        int got;
        got = 0;
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = dt;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (scramble) begin
                addr[d]  = 8'($urandom);
                wdata[d] = 16'($urandom);
            end
            @(posedge clk); #1;
            if (ack[d]) begin
                got = n;
                break;
            end
        end
        check({tag, "_lat"}, got, lat);
        check({tag, "_err"}, {31'd0, err[d]}, {31'd0, exp_err});
        check({tag, "_rdata"}, {16'd0, rdata[d]}, {16'd0, exp_rd});
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_ackpulse"}, {31'd0, ack[d]}, 32'd0);
            check({tag, "_busyrel"}, {31'd0, busy[d]}, 32'd1);
        end
        @(negedge clk);
        req[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle"}, {31'd0, busy[d]}, 32'd0);
    endtask

    initial begin
        bit saw_ack;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_ack", {31'd0, ack[i]}, 32'd0);
            check("rst_err", {31'd0, err[i]}, 32'd0);
            check("rst_busy", {31'd0, busy[i]}, 32'd0);
            check("rst_rdata", {16'd0, rdata[i]}, 32'd0);
`ifdef SIF_WA_CHECKSUM_EN
            check("rst_chk", {16'd0, chk[i]}, 32'd0);
`endif
        end
        rst = 1'b0;

        // Two wait states, full depth
        txn(0, 1, 8'h05, 16'hA5A5, 3, 0, 16'h0000, 0, 0, "w05");
        txn(0, 0, 8'h05, 16'h0000, 3, 0, 16'hA5A5, 0, 0, "r05");
        txn(0, 1, 8'h01, 16'h1111, 3, 0, 16'hA5A5, 0, 0, "w01");
        txn(0, 1, 8'h03, 16'h3333, 3, 0, 16'hA5A5, 0, 0, "w03");
        txn(0, 1, 8'h02, 16'h5555, 3, 0, 16'hA5A5, 1, 0, "w02scr");
        txn(0, 0, 8'h02, 16'h0000, 3, 0, 16'h5555, 0, 0, "r02");
        txn(0, 0, 8'h01, 16'h0000, 3, 0, 16'h1111, 0, 0, "r01");
        txn(0, 0, 8'h03, 16'h0000, 3, 0, 16'h3333, 0, 0, "r03");
        txn(0, 0, 8'h05, 16'h0000, 3, 0, 16'hA5A5, 0, 0, "r05b");
        txn(0, 1, 8'hFF, 16'hBEEF, 3, 0, 16'hA5A5, 0, 0, "wFF");
        txn(0, 0, 8'hFF, 16'h0000, 3, 0, 16'hBEEF, 0, 0, "rFF");
        txn(0, 1, 8'h07, 16'h0BAD, 3, 0, 16'hBEEF, 0, 0, "w07pre");

        // Zero wait states, request held beyond the ack
        txn(1, 1, 8'h10, 16'h1234, 1, 0, 16'h0000, 0, 4, "z_w10");
        txn(1, 0, 8'h10, 16'h0000, 1, 0, 16'h1234, 0, 0, "z_r10");

        // DEPTH=200 address range
        txn(2, 1, 8'hC7, 16'h7777, 3, 0, 16'h0000, 0, 0, "d_wC7");
        txn(2, 0, 8'hC7, 16'h0000, 3, 0, 16'h7777, 0, 0, "d_rC7");
        txn(2, 1, 8'hC8, 16'hFFFF, 3, 1, 16'h7777, 0, 0, "d_wC8");
        txn(2, 0, 8'hC8, 16'h0000, 3, 1, 16'h0000, 0, 0, "d_rC8");
        txn(2, 0, 8'hC7, 16'h0000, 3, 0, 16'h7777, 0, 0, "d_rC7b");

        // Reset one cycle into WAIT of a write
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h07; wdata[0] = 16'hBEEF;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ack", {31'd0, ack[0]}, 32'd0);
        check("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
        check("mid_rst_err", {31'd0, err[0]}, 32'd0);
        check("mid_rst_rdata", {16'd0, rdata[0]}, 32'd0);
        @(negedge clk);
        req[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        saw_ack = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack[0]) saw_ack = 1'b1;
        end
        check("mid_rst_noack", {31'd0, saw_ack}, 32'd0);
        txn(0, 0, 8'h07, 16'h0000, 3, 0, 16'h0BAD, 0, 0, "r07nocommit");
        txn(0, 1, 8'h07, 16'h0001, 3, 0, 16'h0BAD, 0, 0, "w07");
        txn(0, 0, 8'h07, 16'h0000, 3, 0, 16'h0001, 0, 0, "r07");

`ifdef SIF_WA_CHECKSUM_EN
        txn(2, 1, 8'h20, 16'hFFFF, 3, 0, 16'h0000, 0, 0, "c_w20");
        check("chk_1", {16'd0, chk[2]}, 32'h0000FFFF);
        txn(2, 1, 8'h21, 16'h0003, 3, 0, 16'h0000, 0, 0, "c_w21");
        check("chk_wrap", {16'd0, chk[2]}, 32'h00000002);
        txn(2, 1, 8'hC8, 16'h1234, 3, 1, 16'h0000, 0, 0, "c_werr");
        check("chk_errwr", {16'd0, chk[2]}, 32'h00000002);
        txn(2, 0, 8'h20, 16'h0000, 3, 0, 16'hFFFF, 0, 0, "c_r20");
        check("chk_read", {16'd0, chk[2]}, 32'h00000002);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
